// File: rtl/left_circ_shift.sv
// Registered left rotations by 1, 2 and 8; right rotations added when LEFT_CIRC_SHIFT_ROR_EN is defined.
// Latency 1 cycle, outputs hold while in_valid=0; no backpressure, accepts a word every cycle.
module left_circ_shift #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic [N-1:0] shiftOneOut,
    output logic [N-1:0] shiftTwoOut,
    output logic [N-1:0] shiftEightOut,
`ifdef LEFT_CIRC_SHIFT_ROR_EN
    output logic [N-1:0] rorOneOut,
    output logic [N-1:0] rorTwoOut,
    output logic [N-1:0] rorEightOut,
`endif
    output logic         out_valid
);

    // Pure wiring permutations; rotate-by-8 needs N >= 9 so both slices are non-empty.
    logic [N-1:0] w_rol1;
    logic [N-1:0] w_rol2;
    logic [N-1:0] w_rol8;

    assign w_rol1 = {in[N-2:0], in[N-1]};
    assign w_rol2 = {in[N-3:0], in[N-1:N-2]};
    assign w_rol8 = {in[N-9:0], in[N-1:N-8]};

    logic [N-1:0] r_rol1;
    logic [N-1:0] r_rol2;
    logic [N-1:0] r_rol8;
    logic         r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rol1 <= '0;
            r_rol2 <= '0;
            r_rol8 <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_rol1 <= w_rol1;
                r_rol2 <= w_rol2;
                r_rol8 <= w_rol8;
            end
        end
    end

    assign shiftOneOut   = r_rol1;
    assign shiftTwoOut   = r_rol2;
    assign shiftEightOut = r_rol8;
    assign out_valid     = r_vld;

`ifdef LEFT_CIRC_SHIFT_ROR_EN
    logic [N-1:0] w_ror1;
    logic [N-1:0] w_ror2;
    logic [N-1:0] w_ror8;

    assign w_ror1 = {in[0], in[N-1:1]};
    assign w_ror2 = {in[1:0], in[N-1:2]};
    assign w_ror8 = {in[7:0], in[N-1:8]};

    logic [N-1:0] r_ror1;
    logic [N-1:0] r_ror2;
    logic [N-1:0] r_ror8;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ror1 <= '0;
            r_ror2 <= '0;
            r_ror8 <= '0;
        end else if (in_valid) begin
            r_ror1 <= w_ror1;
            r_ror2 <= w_ror2;
            r_ror8 <= w_ror8;
        end
    end

    assign rorOneOut   = r_ror1;
    assign rorTwoOut   = r_ror2;
    assign rorEightOut = r_ror8;
`endif

endmodule

// File: tb/tb_left_circ_shift.sv
// Randomized check of left_circ_shift (N=16 and N=32) against an index-arithmetic rotation model.
module tb_left_circ_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in16;
    logic [31:0] in32;

    logic [15:0] a_one, a_two, a_eight;
    logic [31:0] b_one, b_two, b_eight;
    logic        a_vld, b_vld;
`ifdef LEFT_CIRC_SHIFT_ROR_EN
    logic [15:0] a_r1, a_r2, a_r8;
    logic [31:0] b_r1, b_r2, b_r8;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    left_circ_shift #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .in(in16), .in_valid(in_valid),
        .shiftOneOut(a_one), .shiftTwoOut(a_two), .shiftEightOut(a_eight),
`ifdef LEFT_CIRC_SHIFT_ROR_EN
        .rorOneOut(a_r1), .rorTwoOut(a_r2), .rorEightOut(a_r8),
`endif
        .out_valid(a_vld)
    );

    left_circ_shift #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .in(in32), .in_valid(in_valid),
        .shiftOneOut(b_one), .shiftTwoOut(b_two), .shiftEightOut(b_eight),
`ifdef LEFT_CIRC_SHIFT_ROR_EN
        .rorOneOut(b_r1), .rorTwoOut(b_r2), .rorEightOut(b_r8),
`endif
        .out_valid(b_vld)
    );

    // Bit i of a left rotation by k is source bit (i-k) mod w.
    function automatic logic [31:0] rotl(input logic [31:0] x, input int w, input int k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = x[(i - k + w) % w];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what each output must hold after the latest edge.
    int          ks[3] = '{1, 2, 8};
    logic [31:0] m16l[3], m16r[3], m32l[3], m32r[3];
    logic        m_vld;
    logic        model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 3; j++) begin
                m16l[j] = '0; m16r[j] = '0; m32l[j] = '0; m32r[j] = '0;
            end
            m_vld = 1'b0;
        end else begin
            if (in_valid) begin
                for (int j = 0; j < 3; j++) begin
                    m16l[j] = rotl({16'h0, in16}, 16, ks[j]);
                    m16r[j] = rotl({16'h0, in16}, 16, 16 - ks[j]);
                    m32l[j] = rotl(in32, 32, ks[j]);
                    m32r[j] = rotl(in32, 32, 32 - ks[j]);
                end
            end
            m_vld = in_valid;
        end
        if (rst) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("n16_rol1", {16'h0, a_one},   m16l[0]);
            chk("n16_rol2", {16'h0, a_two},   m16l[1]);
            chk("n16_rol8", {16'h0, a_eight}, m16l[2]);
            chk("n16_vld",  {31'h0, a_vld},   {31'h0, m_vld});
            chk("n32_rol1", b_one,   m32l[0]);
            chk("n32_rol2", b_two,   m32l[1]);
            chk("n32_rol8", b_eight, m32l[2]);
            chk("n32_vld",  {31'h0, b_vld},   {31'h0, m_vld});
`ifdef LEFT_CIRC_SHIFT_ROR_EN
            chk("n16_ror1", {16'h0, a_r1}, m16r[0]);
            chk("n16_ror2", {16'h0, a_r2}, m16r[1]);
            chk("n16_ror8", {16'h0, a_r8}, m16r[2]);
            chk("n32_ror1", b_r1, m32r[0]);
            chk("n32_ror2", b_r2, m32r[1]);
            chk("n32_ror8", b_r8, m32r[2]);
`endif
        end
    end

    // Present inputs now, then return 2 time units after the edge that captures them.
    task automatic cyc(input logic r, input logic v, input logic [15:0] d16, input logic [31:0] d32);
        rst = r; in_valid = v; in16 = d16; in32 = d32;
        @(posedge clk);
        #2;
    endtask

    task automatic lit16(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                         input logic [15:0] e8, input logic ev);
        chk({tag, "_one"},   {16'h0, a_one},   {16'h0, e1});
        chk({tag, "_two"},   {16'h0, a_two},   {16'h0, e2});
        chk({tag, "_eight"}, {16'h0, a_eight}, {16'h0, e8});
        chk({tag, "_vld"},   {31'h0, a_vld},   {31'h0, ev});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in16 = '0; in32 = '0;
        cyc(1'b1, 1'b0, 16'h0, 32'h0);
        cyc(1'b1, 1'b0, 16'h0, 32'h0);
        lit16("reset_state", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        cyc(1'b0, 1'b1, 16'hA48F, 32'h8000_0001);
        lit16("a48f", 16'h491F, 16'h923E, 16'h8FA4, 1'b1);
        chk("model_pin_rol1", m16l[0], 32'h0000_491F);
        chk("n32_lit_one",   b_one,   32'h0000_0003);
        chk("n32_lit_two",   b_two,   32'h0000_0006);
        chk("n32_lit_eight", b_eight, 32'h0000_0180);
`ifdef LEFT_CIRC_SHIFT_ROR_EN
        chk("ror_lit_one",   {16'h0, a_r1}, 32'h0000_D247);
        chk("ror_lit_two",   {16'h0, a_r2}, 32'h0000_E923);
        chk("ror_lit_eight", {16'h0, a_r8}, 32'h0000_8FA4);
`endif

        for (int h = 0; h < 3; h++) begin
            cyc(1'b0, 1'b0, 16'hFFFF, 32'hFFFF_FFFF);
            lit16("hold", 16'h491F, 16'h923E, 16'h8FA4, 1'b0);
        end

        cyc(1'b0, 1'b1, 16'hF0F0, 32'h0);
        lit16("f0f0", 16'hE1E1, 16'hC3C3, 16'hF0F0, 1'b1);
        cyc(1'b0, 1'b1, 16'hCCCC, 32'h0);
        lit16("cccc", 16'h9999, 16'h3333, 16'hCCCC, 1'b1);
        cyc(1'b0, 1'b1, 16'hF1F1, 32'h0);
        lit16("f1f1", 16'hE3E3, 16'hC7C7, 16'hF1F1, 1'b1);

        cyc(1'b1, 1'b1, 16'hF0F0, 32'hF0F0_F0F0);
        lit16("rst_prio", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk("model_pin_rst", m16l[2], 32'h0);

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 70),
                16'($urandom_range(0, 65535)), 32'($urandom));
        end
        cyc(1'b0, 1'b0, 16'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/left_circ_shift.md
LEFT_CIRC_SHIFT -- requirements
Module: left_circ_shift

Interface
REQ-001 SHALL have parameter N, default 16: data word width in bits; legal range N >= 9.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-high, sampled on rising clk.
REQ-004 SHALL have port in, input, N bits: word to rotate.
REQ-005 SHALL have port in_valid, input, 1 bit: qualifies in on the current cycle.
REQ-006 SHALL have port shiftOneOut, output, N bits: registered left rotation of in by 1.
REQ-007 SHALL have port shiftTwoOut, output, N bits: registered left rotation of in by 2.
REQ-008 SHALL have port shiftEightOut, output, N bits: registered left rotation of in by 8.
REQ-009 SHALL have port out_valid, output, 1 bit: high when the three rotation outputs hold a result.

Function
REQ-010 SHALL compute each rotation circularly: bit i of a rotate-left-by-k result equals in[(i-k) mod N]; no bit is lost or zero-filled.
REQ-011 SHALL register all outputs with latency exactly 1 cycle: in sampled with in_valid=1 at edge t appears on the outputs after edge t.
REQ-012 SHALL hold all rotation outputs unchanged on any cycle with in_valid=0.
REQ-013 SHALL drive out_valid to the value of in_valid registered on the previous edge.
REQ-014 SHALL accept a new word every cycle (no backpressure, no stall); back-to-back valid inputs produce back-to-back results.
REQ-015 SHALL use no arithmetic, only bit permutation; output widths equal N exactly.
REQ-016 SHALL satisfy rotate-by-2 equal to rotate-by-1 applied twice, and rotate-by-8 of a 16-bit word equal a byte swap.

Reset
REQ-017 SHALL, when rst=1 at a rising edge, clear shiftOneOut, shiftTwoOut, shiftEightOut (and any optional outputs) to all zeros and out_valid to 0.
REQ-018 SHALL give rst priority over in_valid on the same edge; the word presented that cycle is discarded.
REQ-019 SHALL resume normal operation on the first edge with rst=0; reset asserted mid-stream drops the in-flight result.

Configuration
REQ-020 SHALL, when macro LEFT_CIRC_SHIFT_ROR_EN is defined, add outputs rorOneOut, rorTwoOut, rorEightOut (each N bits): right rotations by 1, 2, 8, with identical register, hold and reset rules as the left-rotation outputs.
REQ-021 SHALL, without LEFT_CIRC_SHIFT_ROR_EN, omit those ports and logic entirely; left-rotation behaviour is identical in both builds.

Verification
REQ-022 SHALL cover: N=16, in=0xA48F valid -> next cycle shiftOneOut=0x491F, shiftTwoOut=0x923E, shiftEightOut=0x8FA4, out_valid=1.
REQ-023 SHALL cover: in=0xF0F0 -> 0xE1E1, 0xC3C3, 0xF0F0; in=0xCCCC -> 0x9999, 0x3333, 0xCCCC; in=0xF1F1 -> 0xE3E3, 0xC7C7, 0xF1F1, applied back-to-back on consecutive cycles.
REQ-024 SHALL cover: hold -- result for 0xA48F present, then in=0xFFFF with in_valid=0 for 3 cycles -> outputs stay 0x491F/0x923E/0x8FA4, out_valid=0.
REQ-025 SHALL cover: reset -- rst=1 with in_valid=1, in=0xF0F0 -> all outputs 0x0000, out_valid=0 after the edge.
REQ-026 SHALL cover: with LEFT_CIRC_SHIFT_ROR_EN, in=0xA48F -> rorOneOut=0xD247, rorTwoOut=0xE923, rorEightOut=0x8FA4.
REQ-027 SHALL cover: N=32, in=0x80000001 -> shiftOneOut=0x00000003, shiftTwoOut=0x00000006, shiftEightOut=0x00000180.
